// File: rtl/reg_file_arbiter.sv
// Round-robin arbiter/sequencer between two requesters (A, B) and an
// 8-entry register file with one read port and one write port.
// Transactions are serialised through IDLE -> ISSUE -> (CAPTURE) -> ACK.
// Every output is a flop. Each output is loaded one state early, so its
// value lines up with the state it belongs to.
module reg_file_arbiter #(
    parameter int Width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             we_a,
    input  logic [2:0]       addr_a,
    input  logic [Width-1:0] wdata_a,
    output logic             ack_a,
    output logic [Width-1:0] rdata_a,
    input  logic             req_b,
    input  logic             we_b,
    input  logic [2:0]       addr_b,
    input  logic [Width-1:0] wdata_b,
    output logic             ack_b,
    output logic [Width-1:0] rdata_b,
    output logic             busy,
    output logic             rf_read_enable,
    output logic             rf_write_enable,
    output logic [2:0]       rf_read_addr,
    output logic [2:0]       rf_write_addr,
    output logic [Width-1:0] rf_write_data,
    input  logic [Width-1:0] rf_read_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

    state_t state, state_next;
    logic   prio;      // 0: A wins a tie, 1: B wins a tie
    logic   sel;       // requester being served, 0: A, 1: B
    logic   sel_we;    // served transaction is a write
    logic   grant;     // some requester is asking (only used in IDLE)
    logic   grant_b;   // B wins arbitration this cycle
    logic             g_we;
    logic [2:0]       g_addr;
    logic [Width-1:0] g_wdata;

    // Arbitration, granted-request mux and next-state decode
    always_comb begin
        state_next = state;
        grant      = req_a | req_b;
        grant_b    = req_b & (~req_a | prio);
        g_we       = grant_b ? we_b    : we_a;
        g_addr     = grant_b ? addr_b  : addr_a;
        g_wdata    = grant_b ? wdata_b : wdata_a;
        case (state)
            IDLE:    if (grant) state_next = ISSUE;
            ISSUE:   state_next = sel_we ? ACK : CAPTURE;
            CAPTURE: state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Latched transaction, priority and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio            <= 1'b0;
            sel             <= 1'b0;
            sel_we          <= 1'b0;
            busy            <= 1'b0;
            ack_a           <= 1'b0;
            ack_b           <= 1'b0;
            rdata_a         <= '0;
            rdata_b         <= '0;
            rf_read_enable  <= 1'b0;
            rf_write_enable <= 1'b0;
            rf_read_addr    <= '0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
        end else begin
            // Pulsed outputs default low; enables only live in ISSUE
            rf_read_enable  <= 1'b0;
            rf_write_enable <= 1'b0;
            ack_a           <= 1'b0;
            ack_b           <= 1'b0;
            busy            <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (grant) begin
                        sel    <= grant_b;
                        sel_we <= g_we;
                        if (g_we) begin
                            rf_write_enable <= 1'b1;
                            rf_write_addr   <= g_addr;
                            rf_write_data   <= g_wdata;
                        end else begin
                            rf_read_enable  <= 1'b1;
                            rf_read_addr    <= g_addr;
                        end
                    end
                end
                ISSUE: begin
                    // A write has committed this cycle, so acknowledge next
                    if (sel_we) begin
                        ack_a <= ~sel;
                        ack_b <= sel;
                    end
                end
                CAPTURE: begin
                    if (sel) rdata_b <= rf_read_data;
                    else     rdata_a <= rf_read_data;
                    ack_a <= ~sel;
                    ack_b <= sel;
                end
                ACK: prio <= ~sel;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Bench for reg_file_arbiter: behavioural register file, scoreboard of
// expected acks/read data, per-cycle trace used by the timing checks.
module tb_reg_file_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [2:0]  addr_a = '0, addr_b = '0;
    logic [15:0] wdata_a = '0, wdata_b = '0;
    logic        ack_a, ack_b, busy;
    logic [15:0] rdata_a, rdata_b;
    logic        rf_read_enable, rf_write_enable;
    logic [2:0]  rf_read_addr, rf_write_addr;
    logic [15:0] rf_write_data;
    logic [15:0] rf_read_data = '0;

    reg_file_arbiter #(.Width(16)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .ack_a(ack_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .ack_b(ack_b), .rdata_b(rdata_b),
        .busy(busy),
        .rf_read_enable(rf_read_enable), .rf_write_enable(rf_write_enable),
        .rf_read_addr(rf_read_addr), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data), .rf_read_data(rf_read_data)
    );

    always #5 clk = ~clk;

    // Register file: read registered at posedge, write commits at negedge
    logic [15:0] mem [8] = '{default: 16'h0000};
    always @(posedge clk) if (rf_read_enable) rf_read_data <= mem[rf_read_addr];
    always @(negedge clk) if (rf_write_enable) mem[rf_write_addr] <= rf_write_data;

    typedef struct {
        logic        side;  // 0: A, 1: B
        logic        rd;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] shadow [8] = '{default: 16'h0000};
    int          errors = 0;
    int          checks = 0;

    // Per-cycle trace; index 1 is the cycle in which the request is driven
    logic [63:0] rec_ack_a, rec_ack_b, rec_we, rec_re, rec_busy;
    logic [2:0]  rec_waddr [64];
    logic [2:0]  rec_raddr [64];
    logic [15:0] rec_wdata [64];
    logic        seq[$];
    int          rem_a, rem_b, raise_at;
    logic [58:0] outs;

    task automatic push_exp(input logic side, input logic we, input logic [2:0] addr,
                            input logic [15:0] data);
        exp_t e;
        e.side = side;
        e.rd   = !we;
        e.data = we ? 16'h0000 : shadow[addr];
        if (we) shadow[addr] = data;
        sb.push_back(e);
    endtask

    // Run until both requesters have used up their transactions; pops the
    // scoreboard on every ack and drops req after the last ack of a side.
    task automatic run(input int bound);
        exp_t e;
        bit   done;
        done = 0;
        rec_ack_a = '0; rec_ack_b = '0; rec_we = '0; rec_re = '0; rec_busy = '0;
        for (int i = 0; i < 64; i++) begin
            rec_waddr[i] = '0; rec_raddr[i] = '0; rec_wdata[i] = '0;
        end
        seq.delete();
        for (int k = 1; k <= bound && k < 64 && !done; k++) begin
            @(negedge clk);
            rec_ack_a[k] = ack_a; rec_ack_b[k] = ack_b;
            rec_we[k] = rf_write_enable; rec_re[k] = rf_read_enable; rec_busy[k] = busy;
            rec_waddr[k] = rf_write_addr; rec_wdata[k] = rf_write_data;
            rec_raddr[k] = rf_read_addr;
            if (ack_a && ack_b) begin
                checks++; errors++;
                $display("FAIL both_ack cycle %0d: ack_a=1 ack_b=1, expected one", k);
            end else if (ack_a || ack_b) begin
                checks++;
                seq.push_back(ack_b);
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_ack cycle %0d: ack_b=%0b, none expected", k, ack_b);
                end else begin
                    e = sb.pop_front();
                    if (e.side !== ack_b ||
                        (e.rd && (ack_b ? rdata_b : rdata_a) !== e.data)) begin
                        errors++;
                        $display("FAIL sb_ack cycle %0d: side=%0b rdata=%h, expected side=%0b rdata=%h",
                                 k, ack_b, ack_b ? rdata_b : rdata_a, e.side, e.data);
                    end
                end
            end
            @(posedge clk); #1;
            if (rec_ack_a[k]) begin rem_a--; if (rem_a <= 0) req_a = 1'b0; end
            if (rec_ack_b[k]) begin rem_b--; if (rem_b <= 0) req_b = 1'b0; end
            if (k == raise_at) req_a = 1'b1;
            if (rem_a <= 0 && rem_b <= 0 && raise_at < k) done = 1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL run_timeout: rem_a=%0d rem_b=%0d after %0d cycles", rem_a, rem_b, bound);
            req_a = 1'b0; req_b = 1'b0;
        end
        raise_at = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_a = 0; req_b = 0; rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        outs = {busy, ack_a, ack_b, rf_read_enable, rf_write_enable, rf_read_addr,
                rf_write_addr, rf_write_data, rdata_a, rdata_b};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected 0", outs);
        end
    endtask

    task automatic test_write();
        @(posedge clk); #1;
        req_a = 1; we_a = 1; addr_a = 3'd3; wdata_a = 16'h1234;
        push_exp(1'b0, 1'b1, 3'd3, 16'h1234);
        rem_a = 1; rem_b = 0;
        run(20);
        checks++;
        if (rec_we[2] !== 1'b1 || rec_waddr[2] !== 3'd3 || rec_wdata[2] !== 16'h1234) begin
            errors++;
            $display("FAIL wr_issue: we=%0b addr=%0d data=%h, expected 1/3/1234",
                     rec_we[2], rec_waddr[2], rec_wdata[2]);
        end
        checks++;
        if ($countones(rec_we) != 1 || $countones(rec_re) != 0) begin
            errors++;
            $display("FAIL wr_enable_count: we=%0d re=%0d, expected 1/0",
                     $countones(rec_we), $countones(rec_re));
        end
        checks++;
        if (rec_ack_a[3] !== 1'b1 || $countones(rec_ack_a) != 1 || rec_ack_b !== '0) begin
            errors++;
            $display("FAIL wr_ack_latency: ack_a trace=%h ack_b trace=%h, expected ack_a only in cycle 3",
                     rec_ack_a, rec_ack_b);
        end
        checks++;
        if (rec_busy[1] !== 1'b0 || rec_busy[2] !== 1'b1) begin
            errors++;
            $display("FAIL wr_busy: busy c1=%0b c2=%0b, expected 0/1", rec_busy[1], rec_busy[2]);
        end
    endtask

    task automatic test_read();
        @(posedge clk); #1;
        req_a = 1; we_a = 0; addr_a = 3'd3;
        push_exp(1'b0, 1'b0, 3'd3, 16'h0);
        rem_a = 1; rem_b = 0;
        run(20);
        checks++;
        if (rec_re[2] !== 1'b1 || rec_raddr[2] !== 3'd3 || $countones(rec_re) != 1 ||
            $countones(rec_we) != 0) begin
            errors++;
            $display("FAIL rd_issue: re c2=%0b addr=%0d re count=%0d we count=%0d, expected 1/3/1/0",
                     rec_re[2], rec_raddr[2], $countones(rec_re), $countones(rec_we));
        end
        checks++;
        if (rec_ack_a[4] !== 1'b1 || $countones(rec_ack_a) != 1) begin
            errors++;
            $display("FAIL rd_ack_latency: ack_a trace=%h, expected only cycle 4", rec_ack_a);
        end
        checks++;
        if (rdata_a !== 16'h1234 || rdata_b !== 16'h0000) begin
            errors++;
            $display("FAIL rd_rdata_hold: rdata_a=%h rdata_b=%h, expected 1234/0000", rdata_a, rdata_b);
        end
    endtask

    task automatic test_both();
        do_reset();
        @(posedge clk); #1;
        req_a = 1; we_a = 1; addr_a = 3'd1; wdata_a = 16'h00AA;
        req_b = 1; we_b = 0; addr_b = 3'd1;
        push_exp(1'b0, 1'b1, 3'd1, 16'h00AA);
        push_exp(1'b1, 1'b0, 3'd1, 16'h0);
        rem_a = 1; rem_b = 1;
        run(30);
        checks++;
        if (seq.size() != 2 || seq[0] !== 1'b0 || seq[1] !== 1'b1) begin
            errors++;
            $display("FAIL both_order: %0d acks first=%0b, expected A then B",
                     seq.size(), seq.size() > 0 ? seq[0] : 1'bx);
        end
        checks++;
        if (rdata_b !== 16'h00AA) begin
            errors++;
            $display("FAIL both_raw: rdata_b=%h, expected 00aa", rdata_b);
        end
    endtask

    // Priority after the previous test points back at A, so A goes first
    task automatic test_fairness();
        int bad;
        @(posedge clk); #1;
        req_a = 1; we_a = 0; addr_a = 3'd3;
        req_b = 1; we_b = 0; addr_b = 3'd1;
        for (int i = 0; i < 4; i++) begin
            push_exp(1'b0, 1'b0, 3'd3, 16'h0);
            push_exp(1'b1, 1'b0, 3'd1, 16'h0);
        end
        rem_a = 4; rem_b = 4;
        run(60);
        bad = 0;
        for (int i = 0; i < seq.size(); i++) if (seq[i] !== 1'(i % 2)) bad++;
        checks++;
        if (seq.size() != 8 || bad != 0) begin
            errors++;
            $display("FAIL fair_alternation: %0d acks, %0d out of order, expected 8 alternating from A",
                     seq.size(), bad);
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        @(posedge clk); #1;
        req_b = 1; we_b = 0; addr_b = 3'd0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rf_read_enable !== 1'b1) begin
            errors++;
            $display("FAIL mid_issue: rf_read_enable=%0b, expected 1", rf_read_enable);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        outs = {busy, ack_a, ack_b, rf_read_enable, rf_write_enable, rf_read_addr,
                rf_write_addr, rf_write_data, rdata_a, rdata_b};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h, expected 0", outs);
        end
        req_b = 0;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack_b || busy || rf_read_enable || rf_write_enable) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL mid_no_ack: activity after dropped transaction, expected idle");
        end
        @(posedge clk); #1;
        req_b = 1; we_b = 0; addr_b = 3'd0;
        push_exp(1'b1, 1'b0, 3'd0, 16'h0);
        rem_a = 0; rem_b = 1;
        run(20);
        checks++;
        if (rec_ack_b[4] !== 1'b1 || rdata_b !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reread: ack_b c4=%0b rdata_b=%h, expected 1/0000", rec_ack_b[4], rdata_b);
        end
    endtask

    task automatic test_late_req();
        @(posedge clk); #1;
        req_b = 1; we_b = 1; addr_b = 3'd7; wdata_b = 16'hFFFF;
        we_a = 0; addr_a = 3'd7;
        push_exp(1'b1, 1'b1, 3'd7, 16'hFFFF);
        push_exp(1'b0, 1'b0, 3'd7, 16'h0);
        rem_a = 1; rem_b = 1; raise_at = 1;
        run(30);
        checks++;
        if (rec_ack_b[3] !== 1'b1 || rec_ack_a[7] !== 1'b1 || rec_re[4:2] !== 3'b000 ||
            rec_re[5] !== 1'b1) begin
            errors++;
            $display("FAIL late_req: ack_b c3=%0b ack_a c7=%0b re c2..5=%b, expected 1/1/1000",
                     rec_ack_b[3], rec_ack_a[7], rec_re[5:2]);
        end
        checks++;
        if (rdata_a !== 16'hFFFF) begin
            errors++;
            $display("FAIL late_rdata: rdata_a=%h, expected ffff", rdata_a);
        end
    endtask

    initial begin
        raise_at = -1; rem_a = 0; rem_b = 0;
        #1;
        test_reset();
        test_write();
        test_read();
        test_both();
        test_fairness();
        test_reset_mid();
        test_late_req();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected acks never seen, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
